lf_accum: RTL and testbench

LF_ACCUM -- requirements
Module: lf_accum

---
 rtl/lf_accum.sv | 147 ++++++++++++++
 tb/tb_lf_accum.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lf_accum.sv
// Grouped accumulator: sums a stream of 32-bit beats per group (closed by in_last)
// through a Ladner-Fischer prefix adder and reports sum, carry-out count and beat count.

module lfadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s_list,
  output logic        c
);

  logic [31:0] w_p0;
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_g_nxt;
  logic [31:0] w_p_nxt;

  // Sparse-tree prefix: at level s every bit with bit s of its index set merges
  // with the last bit of the preceding 2^s-aligned block.
  always_comb begin
    w_p0 = a ^ b;
    w_g  = a & b;
    w_p  = w_p0;
    for (int s = 0; s < 5; s++) begin
      w_g_nxt = w_g;
      w_p_nxt = w_p;
      for (int i = 0; i < 32; i++) begin
        if (((i >> s) & 1) == 1) begin
          w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[((i >> s) << s) - 1]);
          w_p_nxt[i] = w_p[i] & w_p[((i >> s) << s) - 1];
        end
      end
      w_g = w_g_nxt;
      w_p = w_p_nxt;
    end
    s_list = w_p0 ^ {w_g[30:0], 1'b0};
    c      = w_g[31];
  end

endmodule

module lf_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_carry_cnt;
  logic             r_out_valid;
  logic [31:0]      r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic [CNT_W-1:0] r_out_carries;
  logic [31:0]      w_sum;
  logic             w_c;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  lfadder u_add (
    .a      (r_acc),
    .b      (in_data),
    .s_list (w_sum),
    .c      (w_c)
  );

  // HOLD accepts a new first beat only in the cycle its result drains.
  assign w_in_ready = rst_n && ((r_state != S_HOLD) || out_ready);
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_in_xfer) w_next = in_last ? S_HOLD : S_ACCUM;
      end
      S_HOLD: begin
        if (w_out_xfer) begin
          if (w_in_xfer) w_next = in_last ? S_HOLD : S_ACCUM;
          else           w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_beat_cnt    <= '0;
      r_carry_cnt   <= '0;
      r_out_valid   <= 1'b0;
      r_out_sum     <= '0;
      r_out_count   <= '0;
      r_out_carries <= '0;
    end else begin
      r_state <= w_next;
      if (w_out_xfer) r_out_valid <= 1'b0;
      if (w_in_xfer) begin
        if (in_last) begin
          r_out_sum     <= w_sum;
          r_out_count   <= sat_inc(r_beat_cnt, 1'b1);
          r_out_carries <= sat_inc(r_carry_cnt, w_c);
          r_out_valid   <= 1'b1;
          r_acc         <= '0;
          r_beat_cnt    <= '0;
          r_carry_cnt   <= '0;
        end else begin
          r_acc         <= w_sum;
          r_beat_cnt    <= sat_inc(r_beat_cnt, 1'b1);
          r_carry_cnt   <= sat_inc(r_carry_cnt, w_c);
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_sum     = r_out_sum;
  assign out_count   = r_out_count;
  assign out_carries = r_out_carries;

endmodule

// File: tb/tb_lf_accum.sv
// Bench for lf_accum: directed scenarios plus random groups checked against an
// arithmetic model (64-bit group total gives sum and wrap count), at CNT_W 8 and 2.

module tb_lf_accum;

  localparam int N_GROUPS  = 3000;
  localparam int MAX_CYCLE = 90000;

  typedef struct {
    logic [31:0] sum;
    int          cnt;
    int          car;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_sum;
  logic [7:0]  out_count, out_carries;
  logic        in_ready_2, out_valid_2;
  logic [31:0] out_sum_2;
  logic [1:0]  out_count_2, out_carries_2;

  int   n_vec = 0;
  int   n_err = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  lf_accum #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_carries(out_carries),
    .out_count(out_count)
  );

  lf_accum #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_2),
    .out_ready(out_ready), .out_sum(out_sum_2), .out_carries(out_carries_2),
    .out_count(out_count_2)
  );

  function automatic int sat(input int x, input int w);
    return (x > (1 << w) - 1) ? (1 << w) - 1 : x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL send_timeout: in_ready=0 for 20 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'd123; in_last = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out_sum, out_count, out_carries,
         in_ready_2, out_valid_2, out_sum_2, out_count_2, out_carries_2} !== '0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b v=%b sum=%h cnt=%0d car=%0d v2=%b, required all 0",
               in_ready, out_valid, out_sum, out_count, out_carries, out_valid_2);
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b v=%b, required rdy=1 v=0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(32'd5, 1'b0); send(32'd7, 1'b0); send(32'd9, 1'b1);
    n_vec++;
    if ({out_valid, out_sum, out_count, out_carries, out_valid_2, out_count_2, out_carries_2}
        !== {1'b1, 32'd21, 8'd3, 8'd0, 1'b1, 2'd3, 2'd0}) begin
      n_err++;
      $display("FAIL basic_sum: v=%b sum=%0d cnt=%0d car=%0d cnt2=%0d, required v=1 sum=21 cnt=3 car=0 cnt2=3",
               out_valid, out_sum, out_count, out_carries, out_count_2);
    end
    step();
    n_vec++;
    if ({out_valid, out_valid_2} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_drain: v=%b v2=%b, required 0 0", out_valid, out_valid_2);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 1'b0); send(32'h0000_0002, 1'b0); send(32'hFFFF_FFFF, 1'b1);
    n_vec++;
    if ({out_valid, out_sum, out_count, out_carries, out_count_2, out_carries_2}
        !== {1'b1, 32'h0, 8'd3, 8'd2, 2'd3, 2'd2}) begin
      n_err++;
      $display("FAIL wrap: v=%b sum=%h cnt=%0d car=%0d car2=%0d, required v=1 sum=0 cnt=3 car=2 car2=2",
               out_valid, out_sum, out_count, out_carries, out_carries_2);
    end
    step();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    repeat (5) send(32'd1, 1'b0);
    send(32'd1, 1'b1);
    n_vec++;
    if ({out_sum, out_count, out_carries, out_sum_2, out_count_2, out_carries_2}
        !== {32'd6, 8'd6, 8'd0, 32'd6, 2'd3, 2'd0}) begin
      n_err++;
      $display("FAIL sat_count: sum=%0d cnt=%0d sum2=%0d cnt2=%0d, required 6 6 6 3",
               out_sum, out_count, out_sum_2, out_count_2);
    end
    step();
    repeat (4) send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    n_vec++;
    if ({out_sum, out_count, out_carries, out_count_2, out_carries_2}
        !== {32'hFFFF_FFFB, 8'd5, 8'd4, 2'd3, 2'd3}) begin
      n_err++;
      $display("FAIL sat_carry: sum=%h cnt=%0d car=%0d cnt2=%0d car2=%0d, required fffffffb 5 4 3 3",
               out_sum, out_count, out_carries, out_count_2, out_carries_2);
    end
    step();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b1);
    n_vec++;
    if ({out_valid, out_sum, out_count, out_carries} !== {1'b1, 32'hDEAD_BEEF, 8'd1, 8'd0}) begin
      n_err++;
      $display("FAIL single_beat: v=%b sum=%h cnt=%0d car=%0d, required 1 deadbeef 1 0",
               out_valid, out_sum, out_count, out_carries);
    end
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, out_sum, out_count, out_carries}
          !== {1'b0, 1'b1, 32'hDEAD_BEEF, 8'd1, 8'd0}) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: rdy=%b v=%b sum=%h cnt=%0d, required 0 1 deadbeef 1",
                 k, in_ready, out_valid, out_sum, out_count);
      end
      step();
    end
    out_ready = 1'b1; in_data = 32'd4; in_last = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_passthru_ready: rdy=%b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_vec++;
    if ({out_valid, out_sum, out_count, out_carries} !== {1'b1, 32'd4, 8'd1, 8'd0}) begin
      n_err++;
      $display("FAIL back_to_back: v=%b sum=%0d cnt=%0d car=%0d, required 1 4 1 0",
               out_valid, out_sum, out_count, out_carries);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_drain: v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(32'd10, 1'b0); send(32'd20, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'd100; in_last = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: rdy=%b, required 0", in_ready);
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_override: v=%b, required 0", out_valid);
    end
    send(32'd3, 1'b0); send(32'd4, 1'b1);
    n_vec++;
    if ({out_valid, out_sum, out_count, out_carries} !== {1'b1, 32'd7, 8'd2, 8'd0}) begin
      n_err++;
      $display("FAIL reset_mid_group: v=%b sum=%0d cnt=%0d car=%0d, required 1 7 2 0",
               out_valid, out_sum, out_count, out_carries);
    end
    step();
    out_ready = 1'b0;
    send(32'd55, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    n_vec++;
    if ({out_valid, out_sum, out_count} !== {1'b0, 32'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_in_hold: v=%b sum=%0d cnt=%0d, required 0 0 0", out_valid, out_sum, out_count);
    end
  endtask

  task automatic test_random();
    int              cyc, groups, beats_left, nb;
    longint unsigned tot;
    logic [31:0]     cur;
    bit              have;
    res_t            e;
    cyc = 0; groups = 0; beats_left = 0; nb = 0; tot = 0; have = 1'b0; cur = '0;
    while ((groups < N_GROUPS || have || exp_q.size() != 0) && cyc < MAX_CYCLE) begin
      if (!have && groups < N_GROUPS) begin
        if (beats_left == 0) beats_left = $urandom_range(1, 20);
        cur  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 15) : $urandom;
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(0, 3) != 0);
      in_data   = have ? cur : $urandom;
      in_last   = have && (beats_left == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: unexpected result sum=%h cnt=%0d, required none", out_sum, out_count);
        end else begin
          e = exp_q.pop_front();
          if ({out_sum, out_count, out_carries, out_sum_2, out_count_2, out_carries_2}
              !== {e.sum, 8'(sat(e.cnt, 8)), 8'(sat(e.car, 8)), e.sum,
                   2'(sat(e.cnt, 2)), 2'(sat(e.car, 2))}) begin
            n_err++;
            $display("FAIL rand_result: sum=%h cnt=%0d car=%0d cnt2=%0d car2=%0d, required sum=%h cnt=%0d car=%0d",
                     out_sum, out_count, out_carries, out_count_2, out_carries_2, e.sum, e.cnt, e.car);
          end
        end
      end
      if (in_valid && in_ready) begin
        tot += longint'(cur);
        nb++;
        beats_left--;
        have = 1'b0;
        if (in_last) begin
          e.sum = tot[31:0];
          e.cnt = nb;
          e.car = int'(tot >> 32);
          exp_q.push_back(e);
          tot = 0; nb = 0; groups++;
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_vec++;
    if (cyc >= MAX_CYCLE) begin
      n_err++;
      $display("FAIL rand_timeout: groups=%0d pending=%0d after %0d cycles, required %0d groups drained",
               groups, exp_q.size(), cyc, N_GROUPS);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
